// File: rtl/multicycle_controller_if.sv
// rtl/multicycle_controller_if.sv - Controller <-> datapath signal bundle for the multicycle CPU.
interface multicycle_controller_if;
    logic [5:0] op_i;
    logic [5:0] funct_i;
    logic       zero_i;
    logic [2:0] alucont_o;
    logic       alusrca_o;
    logic [1:0] alusrcb_o;
    logic       iord_o;
    logic       memtoreg_o;
    logic       regdst_o;
    logic [1:0] pcsrc_o;
    logic       pcen_o;
    logic       irwrite_o;
    logic       regwrite_o;
    logic       memwrite_o;
    logic       illegal_o;
    logic [3:0] state_o;

    modport slave (
        input  op_i, funct_i, zero_i,
        output alucont_o, alusrca_o, alusrcb_o, iord_o, memtoreg_o, regdst_o,
               pcsrc_o, pcen_o, irwrite_o, regwrite_o, memwrite_o, illegal_o, state_o
    );

    modport master (
        output op_i, funct_i, zero_i,
        input  alucont_o, alusrca_o, alusrcb_o, iord_o, memtoreg_o, regdst_o,
               pcsrc_o, pcen_o, irwrite_o, regwrite_o, memwrite_o, illegal_o, state_o
    );
endinterface

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - Moore FSM sequencing the multicycle CPU datapath (lw/sw/R/beq/addi/j).
module multicycle_controller (
    input  logic                    clk_i,
    input  logic                    rst_i,
    multicycle_controller_if.slave  ctl
);
    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11
    } state_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t     state;
    state_t     next_state;
    logic [2:0] alucont;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       iord;
    logic       memtoreg;
    logic       regdst;
    logic [1:0] pcsrc;
    logic       pcwrite;
    logic       branch;
    logic       irwrite;
    logic       regwrite;
    logic       memwrite;
    logic       illegal;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= S_FETCH;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = S_FETCH;
        alucont    = 3'b010;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        iord       = 1'b0;
        memtoreg   = 1'b0;
        regdst     = 1'b0;
        pcsrc      = 2'b00;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        irwrite    = 1'b0;
        regwrite   = 1'b0;
        memwrite   = 1'b0;
        illegal    = 1'b0;
        case (state)
            S_FETCH: begin
                next_state = S_DECODE;
                alusrcb    = 2'b01;
                irwrite    = 1'b1;
                pcwrite    = 1'b1;
            end
            S_DECODE: begin
                alusrcb = 2'b11;
                case (ctl.op_i)
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_RTYPE:     next_state = S_RTYPEEX;
                    OP_BEQ:       next_state = S_BEQEX;
                    OP_ADDI:      next_state = S_ADDIEX;
                    OP_J:         next_state = S_JEX;
                    default: begin
                        next_state = S_FETCH;
                        illegal    = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                next_state = (ctl.op_i == OP_LW) ? S_MEMRD : S_MEMWR;
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
            end
            S_MEMRD: begin
                next_state = S_MEMWB;
                iord       = 1'b1;
            end
            S_MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            S_MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            S_RTYPEEX: begin
                next_state = S_RTYPEWB;
                alusrca    = 1'b1;
                case (ctl.funct_i)
                    6'b100010: alucont = 3'b110;
                    6'b100100: alucont = 3'b000;
                    6'b100101: alucont = 3'b001;
                    6'b101010: alucont = 3'b111;
                    default:   alucont = 3'b010;
                endcase
            end
            S_RTYPEWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            S_BEQEX: begin
                alusrca = 1'b1;
                alucont = 3'b110;
                pcsrc   = 2'b01;
                branch  = 1'b1;
            end
            S_ADDIEX: begin
                next_state = S_ADDIWB;
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
            end
            S_ADDIWB: begin
                regwrite = 1'b1;
            end
            S_JEX: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
            default: next_state = S_FETCH;
        endcase
    end

    // Write enables and the illegal pulse are suppressed while reset is held so
    // an abandoned instruction can never commit.
    assign ctl.pcen_o     = ~rst_i & (pcwrite | (branch & ctl.zero_i));
    assign ctl.irwrite_o  = ~rst_i & irwrite;
    assign ctl.regwrite_o = ~rst_i & regwrite;
    assign ctl.memwrite_o = ~rst_i & memwrite;
    assign ctl.illegal_o  = ~rst_i & illegal;

    assign ctl.alucont_o  = alucont;
    assign ctl.alusrca_o  = alusrca;
    assign ctl.alusrcb_o  = alusrcb;
    assign ctl.iord_o     = iord;
    assign ctl.memtoreg_o = memtoreg;
    assign ctl.regdst_o   = regdst;
    assign ctl.pcsrc_o    = pcsrc;
    assign ctl.state_o    = state;
endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - Randomized instruction-level check of multicycle_controller.
module tb_multicycle_controller;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    multicycle_controller_if bus ();

    multicycle_controller dut (
        .clk_i (clk),
        .rst_i (rst),
        .ctl   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] state;
        logic [2:0] alucont;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic       iord;
        logic       memtoreg;
        logic       regdst;
        logic [1:0] pcsrc;
        logic       pcen;
        logic       irwrite;
        logic       regwrite;
        logic       memwrite;
        logic       illegal;
    } ctl_t;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic bit is_supported(input logic [5:0] op);
        return op inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
    endfunction

    function automatic ctl_t expect_ctl(input int st, input logic [5:0] op, input logic [5:0] funct,
                                        input logic zero, input logic rst_now);
        ctl_t e;
        e = '0;
        e.state   = 4'(st);
        e.alucont = 3'b010;
        case (st)
            0:  begin e.alusrcb = 2'b01; e.irwrite = 1'b1; e.pcen = 1'b1; end
            1:  begin e.alusrcb = 2'b11; e.illegal = !is_supported(op); end
            2, 9: begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
            3:  e.iord = 1'b1;
            4:  begin e.memtoreg = 1'b1; e.regwrite = 1'b1; end
            5:  begin e.iord = 1'b1; e.memwrite = 1'b1; end
            6:  begin
                    e.alusrca = 1'b1;
                    e.alucont = (funct == 6'b100010) ? 3'b110 :
                                (funct == 6'b100100) ? 3'b000 :
                                (funct == 6'b100101) ? 3'b001 :
                                (funct == 6'b101010) ? 3'b111 : 3'b010;
                end
            7:  begin e.regdst = 1'b1; e.regwrite = 1'b1; end
            8:  begin e.alusrca = 1'b1; e.alucont = 3'b110; e.pcsrc = 2'b01; e.pcen = zero; end
            10: e.regwrite = 1'b1;
            11: begin e.pcsrc = 2'b10; e.pcen = 1'b1; end
            default: ;
        endcase
        if (rst_now) begin
            e.pcen = 1'b0; e.irwrite = 1'b0; e.regwrite = 1'b0; e.memwrite = 1'b0; e.illegal = 1'b0;
        end
        return e;
    endfunction

    // One instruction: the state walk comes from its cycles-per-instruction schedule.
    // zero_mode < 0 randomizes zero_i; rst_step >= 0 asserts reset on that step.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] funct,
                             input int zero_mode, input int rst_step);
        int   sched[$];
        bit   is_mem;
        ctl_t e;
        case (op)
            6'b100011: sched = '{0, 1, 2, 3, 4};
            6'b101011: sched = '{0, 1, 2, 5};
            6'b000000: sched = '{0, 1, 6, 7};
            6'b001000: sched = '{0, 1, 9, 10};
            6'b000100: sched = '{0, 1, 8};
            6'b000010: sched = '{0, 1, 11};
            default:   sched = '{0, 1};
        endcase
        is_mem = (op == 6'b100011) || (op == 6'b101011);
        for (int k = 0; k < sched.size(); k++) begin
            rst = (k == rst_step);
            bus.op_i    = (k == 1 || (k == 2 && is_mem)) ? op : 6'($urandom);
            bus.funct_i = (sched[k] == 6) ? funct : 6'($urandom);
            bus.zero_i  = (zero_mode < 0) ? 1'($urandom) : 1'(zero_mode);
            #1;
            e = expect_ctl(sched[k], bus.op_i, bus.funct_i, bus.zero_i, rst);
            check_eq("state",    32'(bus.state_o),    32'(e.state));
            check_eq("alucont",  32'(bus.alucont_o),  32'(e.alucont));
            check_eq("alusrca",  32'(bus.alusrca_o),  32'(e.alusrca));
            check_eq("alusrcb",  32'(bus.alusrcb_o),  32'(e.alusrcb));
            check_eq("iord",     32'(bus.iord_o),     32'(e.iord));
            check_eq("memtoreg", 32'(bus.memtoreg_o), 32'(e.memtoreg));
            check_eq("regdst",   32'(bus.regdst_o),   32'(e.regdst));
            check_eq("pcsrc",    32'(bus.pcsrc_o),    32'(e.pcsrc));
            check_eq("pcen",     32'(bus.pcen_o),     32'(e.pcen));
            check_eq("irwrite",  32'(bus.irwrite_o),  32'(e.irwrite));
            check_eq("regwrite", 32'(bus.regwrite_o), 32'(e.regwrite));
            check_eq("memwrite", 32'(bus.memwrite_o), 32'(e.memwrite));
            check_eq("illegal",  32'(bus.illegal_o),  32'(e.illegal));
            @(posedge clk);
            #1;
            if (k == rst_step) break;
        end
        rst = 1'b0;
    endtask

    initial begin
        logic [5:0] ops[7];
        logic [5:0] functs[5];
        logic [5:0] op;
        logic [5:0] funct;
        int         rs;
        ops    = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010, 6'b111111};
        functs = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

        bus.op_i    = 6'b100011;
        bus.funct_i = 6'd0;
        bus.zero_i  = 1'b0;
        rst         = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_state",    32'(bus.state_o),    32'd0);
        check_eq("rst_pcen",     32'(bus.pcen_o),     32'd0);
        check_eq("rst_irwrite",  32'(bus.irwrite_o),  32'd0);
        check_eq("rst_alusrcb",  32'(bus.alusrcb_o),  32'd1);
        check_eq("rst_illegal",  32'(bus.illegal_o),  32'd0);
        rst = 1'b0;

        run_instr(6'b100011, 6'd0,      -1, -1);
        run_instr(6'b000000, 6'b101010, -1, -1);
        run_instr(6'b000100, 6'd0,       1, -1);
        run_instr(6'b000100, 6'd0,       0, -1);
        run_instr(6'b101011, 6'd0,      -1, -1);
        run_instr(6'b000010, 6'd0,      -1, -1);
        run_instr(6'b111111, 6'd0,      -1, -1);
        run_instr(6'b001000, 6'd0,      -1, -1);
        run_instr(6'b100011, 6'd0,      -1,  3);
        run_instr(6'b100011, 6'd0,      -1, -1);

        for (int i = 0; i < 300; i++) begin
            rs = $urandom_range(0, 6);
            op = (rs == 6) ? 6'($urandom) : ops[rs];
            funct = ($urandom_range(0, 5) == 5) ? 6'($urandom) : functs[$urandom_range(0, 4)];
            run_instr(op, funct, -1, ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 4)) : -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
